// File: rtl/seq_slot_allocator.sv
// seq_slot_allocator: bitmap allocator for WAN sequence-number slots.
// Offers the lowest free slot one-hot over valid/ready; frees via i_free_*.
// Ports: i_clk, i_aresetn (async low), i_clear (sync clear),
//   o_grant_valid/o_grant_one_hot/i_grant_ready (grant handshake),
//   i_free_valid/i_free_one_hot (release), o_free_err (reject pulse),
//   o_full (bitmap all ones), o_used_count (set bitmap bits).
// Option: define SEQ_SLOT_ALLOCATOR_ROUND_ROBIN_EN for round-robin search.
module seq_slot_allocator #(
    parameter  int NUM_SLOTS   = 256,
    localparam int COUNT_WIDTH = $clog2(NUM_SLOTS) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_aresetn,
    input  logic                   i_clear,
    output logic                   o_grant_valid,
    output logic [NUM_SLOTS-1:0]   o_grant_one_hot,
    input  logic                   i_grant_ready,
    input  logic                   i_free_valid,
    input  logic [NUM_SLOTS-1:0]   i_free_one_hot,
    output logic                   o_free_err,
    output logic                   o_full,
    output logic [COUNT_WIDTH-1:0] o_used_count
);

    logic [NUM_SLOTS-1:0]   used_q, used_d;
    logic                   gv_q, gv_d;
    logic [NUM_SLOTS-1:0]   oh_q, oh_d;
    logic                   err_q, err_d;
    logic                   full_q, full_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [NUM_SLOTS-1:0]   cand;
    logic                   load;
    logic                   free_is_oh;
    logic                   accept;
    logic [NUM_SLOTS-1:0]   free_mask;

`ifdef SEQ_SLOT_ALLOCATOR_ROUND_ROBIN_EN
    localparam int DW = 2 * NUM_SLOTS;
    localparam logic [NUM_SLOTS-1:0] LAST_RST = {1'b1, {(NUM_SLOTS-1){1'b0}}};

    logic [NUM_SLOTS-1:0] last_q, last_d;
    logic [NUM_SLOTS-1:0] free_map;
    logic [NUM_SLOTS-1:0] above;
    logic [DW-1:0]        dbl;
    logic [DW-1:0]        dbl_pick;

    // Low half holds free slots strictly above last, high half all free
    // slots; the lowest set bit of the pair is the wrapped search result.
    always_comb begin
        free_map = ~used_q;
        above    = ~(last_q | (last_q - NUM_SLOTS'(1)));
        dbl      = {free_map, free_map & above};
        dbl_pick = dbl & (~dbl + DW'(1));
        cand     = dbl_pick[NUM_SLOTS-1:0] | dbl_pick[DW-1:NUM_SLOTS];
    end

    always_comb begin
        last_d = last_q;
        if (i_clear) begin
            last_d = LAST_RST;
        end else if (load) begin
            last_d = cand;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Lowest clear bit of the bitmap; zero when every slot is taken.
    always_comb begin
        cand = ~used_q & (used_q + NUM_SLOTS'(1));
    end
`endif

    always_comb begin
        load = (!gv_q || i_grant_ready) && (cand != '0) && !i_clear;

        free_is_oh = (i_free_one_hot != '0) &&
                     ((i_free_one_hot & (i_free_one_hot - NUM_SLOTS'(1))) == '0);

        // The slot currently on offer is reserved but not yet owned.
        accept = i_free_valid && free_is_oh &&
                 ((i_free_one_hot & used_q) != '0) &&
                 !(gv_q && (i_free_one_hot == oh_q));

        free_mask = accept ? i_free_one_hot : '0;
    end

    always_comb begin
        used_d  = (used_q & ~free_mask) | (load ? cand : '0);
        gv_d    = gv_q;
        oh_d    = oh_q;
        count_d = count_q + COUNT_WIDTH'(load) - COUNT_WIDTH'(accept);
        err_d   = i_free_valid && !accept;

        if (load) begin
            gv_d = 1'b1;
            oh_d = cand;
        end else if (gv_q && i_grant_ready) begin
            gv_d = 1'b0;
            oh_d = '0;
        end

        if (i_clear) begin
            used_d  = '0;
            gv_d    = 1'b0;
            oh_d    = '0;
            count_d = '0;
            err_d   = 1'b0;
        end

        full_d = &used_d;
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            used_q  <= '0;
            gv_q    <= 1'b0;
            oh_q    <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            count_q <= '0;
        end else begin
            used_q  <= used_d;
            gv_q    <= gv_d;
            oh_q    <= oh_d;
            err_q   <= err_d;
            full_q  <= full_d;
            count_q <= count_d;
        end
    end

    assign o_grant_valid   = gv_q;
    assign o_grant_one_hot = oh_q;
    assign o_free_err      = err_q;
    assign o_full          = full_q;
    assign o_used_count    = count_q;

endmodule

// File: doc/seq_slot_allocator.md
Name: seq_slot_allocator

Overview:
- Tracks a bitmap of in-use WAN sequence-number slots.
- Hands out the lowest free slot as a one-hot word over a valid/ready handshake, and returns slots on a free port.
- Sits directly upstream of the one-hot-to-binary decoder in the sequence number initializer. o_grant_one_hot feeds that decoder, which adds 1 downstream.
- Output is registered. At most one grant per cycle is sustained.

Parameters:
- NUM_SLOTS, 256: number of slots. Must be a power of 2 and at least 2.
- COUNT_WIDTH, $clog2(NUM_SLOTS)+1 (localparam): width of the occupancy counter.

Ports:
- i_clk  in  1  clock.
- i_aresetn  in  1  reset, asynchronous, active-low.
- i_clear  in  1  synchronous clear of all slots.
- o_grant_valid  out  1  grant word is valid.
- o_grant_one_hot  out  NUM_SLOTS  slot being offered. Exactly one bit set while valid, else 0.
- i_grant_ready  in  1  consumer accepts the grant.
- i_free_valid  in  1  free request.
- i_free_one_hot  in  NUM_SLOTS  slot to release.
- o_free_err  out  1  one-cycle pulse: a free request was rejected.
- o_full  out  1  all slots reserved or granted.
- o_used_count  out  COUNT_WIDTH  number of set bitmap bits.

Behaviour:
- State:
  - Bitmap `used[NUM_SLOTS]`.
  - Output holding register (valid flag plus one-hot).
  - Counter.
- Reset (async assert, sync release):
  - used=0, o_grant_valid=0, o_grant_one_hot=0, o_free_err=0, o_full=0, o_used_count=0.
- Candidate: `cand = ~used & (used + 1)`, the lowest clear bit, computed from the current registered bitmap. `cand==0` means full.
- Load condition: `load = (!o_grant_valid || (o_grant_valid && i_grant_ready)) && cand != 0 && !i_clear`.
- On load:
  - The holding register takes cand and o_grant_valid=1.
  - used |= cand, so the slot is reserved while offered.
  - The counter increments.
- Handshake without load: o_grant_valid=0 and o_grant_one_hot=0 next cycle.
- Handshake behaviour:
  - Handshake and reload happen in the same cycle, giving 1 grant/cycle.
  - The offered one-hot must not change while valid and not ready.
- First grant: the first cycle after reset release presents slot 0 (one_hot=1).
- Free acceptance. A free is accepted iff all of:
  - i_free_valid=1,
  - $onehot(i_free_one_hot),
  - (i_free_one_hot & used) != 0,
  - not (o_grant_valid && i_free_one_hot == o_grant_one_hot), i.e. the currently offered slot cannot be freed.
- Accepted free: used &= ~i_free_one_hot and the counter decrements.
- Rejected free: the bitmap is unchanged and o_free_err=1 for one cycle.
- Simultaneous free and load:
  - cand is computed from the pre-free bitmap.
  - Next used = (used & ~free) | cand.
  - Next count = count + load - accept, so it is unchanged when both occur.
  - The freed slot becomes eligible the following cycle.
- Full:
  - o_full is registered, =1 when the next bitmap is all ones.
  - While full and the holding register is empty, o_grant_valid stays 0.
  - A free makes the slot offerable 1 cycle after the bitmap update, i.e. 2 cycles after the free.
- i_clear (highest priority):
  - Next cycle: used=0, holding register empty, count=0, o_free_err=0.
  - A free in the same cycle is discarded silently.
  - A pending offer is dropped even if ready=1.
  - Loading resumes the cycle after clear deasserts.
- Reset mid-operation: all state returns immediately to reset values. No grant survives.

Optional Feature:
- Macro: SEQ_SLOT_ALLOCATOR_ROUND_ROBIN_EN.
- With the macro defined:
  - A registered pointer `last` (one-hot, reset to bit NUM_SLOTS-1) updates to the slot on each load.
  - cand is the first clear bit strictly above last, wrapping to bit 0. This uses the double-width mask-and-rotate search.
  - The pointer resets on i_clear.
- Without the macro: lowest-index search as specified above. No pointer register.

Test Plan:
- NUM_SLOTS=8, i_grant_ready held 1 after reset → grants 0x01,0x02,0x04,…,0x80 on consecutive cycles. Then o_full=1, o_grant_valid=0, o_used_count=8.
- Full bitmap, free 0x08 → no error. o_full drops next cycle, grant 0x08 offered the cycle after, count 7→8.
- Free 0x20 while slot 5 unused; free 0x03; free 0x00; free equal to the offered word → o_free_err pulses 1 cycle each, bitmap and count unchanged.
- Offer 0x01 with ready=0 for 5 cycles → o_grant_one_hot stable at 0x01. Ready=1 → next cycle offers 0x02.
- Same-cycle accept of 0x04 and free of 0x01 → next offer 0x08 (0x01 not eligible that cycle). The following load after the next accept picks 0x01.
- Round-robin build: grant 0x01, 0x02, free 0x01 → next grant 0x04, not 0x01. i_clear mid-stream → o_grant_valid=0, count=0, next grant 0x01.
